// File: rtl/armleocpu_itcm_responder.sv
`default_nettype none
// ============================================================================
// Module   : armleocpu_itcm_responder
// Brief    : Instruction tightly-coupled memory answering the fetch unit's
//            cache command/response interface (EXECUTE and FLUSH_ALL), with
//            a backdoor write port used by the debug/loader logic.
//            Optional macro ARMLEOCPU_ITCM_ZERO_INIT_EN clears the memory
//            after reset, one word per cycle, before accepting commands.
// Revision : 1.0 - initial release
// ============================================================================
module armleocpu_itcm_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
  parameter int          DEPTH        = 1024,
  parameter int          WAIT_STATES  = 1,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               c_cmd,
  input  logic [31:0]              c_address,
  output logic [3:0]               c_response,
  output logic                     c_reset_done,
  output logic [31:0]              c_load_data,
  input  logic                     lw_valid,
  input  logic [$clog2(DEPTH)-1:0] lw_addr,
  input  logic [31:0]              lw_data
);

  localparam int IDXW = $clog2(DEPTH);

  // Command / response encodings shared with the fetch unit.
  // PAGEFAULT (4'd4) exists in the response set but is never produced here.
  localparam logic [3:0] C_CMD_NONE      = 4'd0;
  localparam logic [3:0] C_CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] C_CMD_FLUSH_ALL = 4'd4;
  localparam logic [3:0] C_RESP_IDLE     = 4'd0;
  localparam logic [3:0] C_RESP_DONE     = 4'd1;
  localparam logic [3:0] C_RESP_WAIT     = 4'd2;
  localparam logic [3:0] C_RESP_MISALIGN = 4'd3;
  localparam logic [3:0] C_RESP_AFAULT   = 4'd5;

  // Base is word aligned, so the word index is a plain subtraction of the
  // index bits (modulo DEPTH) once the address is known to be in range.
  localparam logic [IDXW-1:0] C_BASE_IDX   = BASE_ADDR[IDXW+1:2];
  localparam logic [32:0]     C_LIMIT      = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  localparam logic [3:0]      C_WAIT_LOAD  = 4'(WAIT_STATES - 1);
  localparam logic [3:0]      C_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  // INIT: post-reset setup; READY: response is IDLE; WAIT: counting down;
  // RESP: response is a single-cycle DONE or error code.
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_READY = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      resp_q, resp_d;
  logic [31:0]     load_q, load_d;
  logic            done_q, done_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            exec_q, exec_d;

  logic [31:0]     mem [DEPTH];

  logic            w_misaligned;
  logic            w_in_range;
  logic [IDXW-1:0] w_addr_idx;
  logic [IDXW-1:0] w_rd_idx;
  logic [31:0]     w_rd_word;
  logic            w_mem_we;
  logic [IDXW-1:0] w_mem_waddr;
  logic [31:0]     w_mem_wdata;

`ifdef ARMLEOCPU_ITCM_ZERO_INIT_EN
  logic            init_run_q, init_run_d;
  logic [IDXW-1:0] init_addr_q, init_addr_d;
`endif

  assign w_misaligned = (c_address[1:0] != 2'b00);
  assign w_in_range   = ({1'b0, c_address} >= {1'b0, BASE_ADDR}) &&
                        ({1'b0, c_address} < C_LIMIT);
  assign w_addr_idx   = c_address[IDXW+1:2] - C_BASE_IDX;

  // Read index comes from the live address when a zero-wait fetch is
  // accepted, otherwise from the latched index of the pending fetch.
  assign w_rd_idx  = (state_q == S_WAIT) ? idx_q : w_addr_idx;
  // Write-first: a backdoor write in the completing cycle is returned.
  assign w_rd_word = (lw_valid && (lw_addr == w_rd_idx)) ? lw_data : mem[w_rd_idx];

  // Write port arbitration: zero-init owns the memory while it runs.
  always_comb begin
    w_mem_we    = lw_valid;
    w_mem_waddr = lw_addr;
    w_mem_wdata = lw_data;
`ifdef ARMLEOCPU_ITCM_ZERO_INIT_EN
    if (state_q == S_INIT) begin
      w_mem_we    = init_run_q;
      w_mem_waddr = init_addr_q;
      w_mem_wdata = 32'h0;
    end
`endif
  end

  // Memory array write (no reset on storage).
  always_ff @(posedge clk) begin
    if (w_mem_we)
      mem[w_mem_waddr] <= w_mem_wdata;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    load_d  = load_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    exec_d  = exec_q;
`ifdef ARMLEOCPU_ITCM_ZERO_INIT_EN
    init_run_d  = init_run_q;
    init_addr_d = init_addr_q;
`endif
    case (state_q)
      S_INIT: begin
`ifdef ARMLEOCPU_ITCM_ZERO_INIT_EN
        // First cycle after release arms the clear; then one word per cycle.
        if (!init_run_q) begin
          init_run_d = 1'b1;
        end else if (init_addr_q == {IDXW{1'b1}}) begin
          init_run_d = 1'b0;
          state_d    = S_READY;
          done_d     = 1'b1;
        end else begin
          init_addr_d = init_addr_q + 1'b1;
        end
`else
        state_d = S_READY;
        done_d  = 1'b1;
`endif
      end
      S_READY, S_RESP: begin
        state_d = S_READY;
        resp_d  = C_RESP_IDLE;
        case (c_cmd)
          C_CMD_NONE: begin
          end
          C_CMD_EXECUTE: begin
            if (w_misaligned) begin
              resp_d  = C_RESP_MISALIGN;
              state_d = S_RESP;
            end else if (!w_in_range) begin
              resp_d  = C_RESP_AFAULT;
              state_d = S_RESP;
            end else begin
              idx_d  = w_addr_idx;
              exec_d = 1'b1;
              if (WAIT_STATES == 0) begin
                resp_d  = C_RESP_DONE;
                load_d  = w_rd_word;
                state_d = S_RESP;
              end else begin
                resp_d  = C_RESP_WAIT;
                cnt_d   = C_WAIT_LOAD;
                state_d = S_WAIT;
              end
            end
          end
          C_CMD_FLUSH_ALL: begin
            exec_d = 1'b0;
            if (FLUSH_CYCLES == 0) begin
              resp_d  = C_RESP_DONE;
              state_d = S_RESP;
            end else begin
              resp_d  = C_RESP_WAIT;
              cnt_d   = C_FLUSH_LOAD;
              state_d = S_WAIT;
            end
          end
          default: begin
            resp_d  = C_RESP_AFAULT;
            state_d = S_RESP;
          end
        endcase
      end
      S_WAIT: begin
        // Commands presented while waiting are ignored.
        if (cnt_q == 4'd0) begin
          resp_d  = C_RESP_DONE;
          state_d = S_RESP;
          if (exec_q)
            load_d = w_rd_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      resp_q  <= C_RESP_IDLE;
      load_q  <= 32'h0;
      done_q  <= 1'b0;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      exec_q  <= 1'b0;
`ifdef ARMLEOCPU_ITCM_ZERO_INIT_EN
      init_run_q  <= 1'b0;
      init_addr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      load_q  <= load_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      exec_q  <= exec_d;
`ifdef ARMLEOCPU_ITCM_ZERO_INIT_EN
      init_run_q  <= init_run_d;
      init_addr_q <= init_addr_d;
`endif
    end
  end

  assign c_response   = resp_q;
  assign c_reset_done = done_q;
  assign c_load_data  = load_q;

endmodule
`default_nettype wire

// File: tb/tb_armleocpu_itcm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_armleocpu_itcm_responder
// Brief    : Directed self-checking bench for armleocpu_itcm_responder
//            (DEPTH=16, WAIT_STATES=1, FLUSH_CYCLES=2, base 0x2000).
// Revision : 1.0 - initial release
// ============================================================================
module tb_armleocpu_itcm_responder;

  localparam int DEPTH = 16;
`ifdef ARMLEOCPU_ITCM_ZERO_INIT_EN
  localparam int RD_LAT = DEPTH + 1;
`else
  localparam int RD_LAT = 1;
`endif

  localparam logic [3:0] CMD_NONE  = 4'd0;
  localparam logic [3:0] CMD_EXEC  = 4'd1;
  localparam logic [3:0] CMD_LOAD  = 4'd2;
  localparam logic [3:0] CMD_FLUSH = 4'd4;
  localparam logic [31:0] R_IDLE  = 32'd0;
  localparam logic [31:0] R_DONE  = 32'd1;
  localparam logic [31:0] R_WAIT  = 32'd2;
  localparam logic [31:0] R_MISAL = 32'd3;
  localparam logic [31:0] R_AFLT  = 32'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic [3:0]  c_response;
  logic        c_reset_done;
  logic [31:0] c_load_data;
  logic        lw_valid;
  logic [3:0]  lw_addr;
  logic [31:0] lw_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  armleocpu_itcm_responder #(
    .BASE_ADDR   (32'h0000_2000),
    .DEPTH       (DEPTH),
    .WAIT_STATES (1),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .c_cmd       (c_cmd),
    .c_address   (c_address),
    .c_response  (c_response),
    .c_reset_done(c_reset_done),
    .c_load_data (c_load_data),
    .lw_valid    (lw_valid),
    .lw_addr     (lw_addr),
    .lw_data     (lw_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [3:0] a, input logic [31:0] d);
    lw_valid = 1'b1;
    lw_addr  = a;
    lw_data  = d;
    tick();
    lw_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; c_cmd = CMD_NONE; c_address = 32'h0;
    lw_valid = 1'b0; lw_addr = 4'd0; lw_data = 32'h0;
    tick(); tick();
    chk("rst_resp", {28'h0, c_response}, R_IDLE);
    chk("rst_done", {31'h0, c_reset_done}, 32'd0);
    chk("rst_load", c_load_data, 32'h0);

    // Release: reset_done low for RD_LAT cycles, then high.
    rst = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      chk("init_done_low", {31'h0, c_reset_done}, 32'd0);
      tick();
    end
    chk("init_done_high", {31'h0, c_reset_done}, 32'd1);
    chk("init_resp", {28'h0, c_response}, R_IDLE);

`ifdef ARMLEOCPU_ITCM_ZERO_INIT_EN
    c_cmd = CMD_EXEC; c_address = 32'h0000_2014;
    tick(); c_cmd = CMD_NONE;
    chk("zi_wait", {28'h0, c_response}, R_WAIT);
    tick();
    chk("zi_done", {28'h0, c_response}, R_DONE);
    chk("zi_data", c_load_data, 32'h0);
    tick();
`endif

    bd_write(4'd3,  32'h0000_0013);
    bd_write(4'd0,  32'hAAAA_0001);
    bd_write(4'd1,  32'hBBBB_0002);
    bd_write(4'd15, 32'hCAFE_000F);

    // Single fetch of word 3.
    c_cmd = CMD_EXEC; c_address = 32'h0000_200C;
    tick(); c_cmd = CMD_NONE;
    chk("f3_wait", {28'h0, c_response}, R_WAIT);
    tick();
    chk("f3_done", {28'h0, c_response}, R_DONE);
    chk("f3_data", c_load_data, 32'h0000_0013);
    tick();
    chk("f3_idle", {28'h0, c_response}, R_IDLE);
    chk("f3_hold", c_load_data, 32'h0000_0013);

    // Back-to-back fetch, EXECUTE held through WAIT.
    c_cmd = CMD_EXEC; c_address = 32'h0000_2000;
    tick();
    chk("b2b_wait0", {28'h0, c_response}, R_WAIT);
    tick();
    chk("b2b_done0", {28'h0, c_response}, R_DONE);
    chk("b2b_data0", c_load_data, 32'hAAAA_0001);
    c_address = 32'h0000_2004;
    tick();
    chk("b2b_wait1", {28'h0, c_response}, R_WAIT);
    tick();
    chk("b2b_done1", {28'h0, c_response}, R_DONE);
    chk("b2b_data1", c_load_data, 32'hBBBB_0002);
    c_cmd = CMD_NONE;
    tick();
    chk("b2b_idle", {28'h0, c_response}, R_IDLE);

    // Error responses, back to back.
    c_cmd = CMD_EXEC; c_address = 32'h0000_2002;
    tick();
    chk("err_misal", {28'h0, c_response}, R_MISAL);
    chk("err_keep", c_load_data, 32'hBBBB_0002);
    c_address = 32'h0000_1FFC;
    tick();
    chk("err_below", {28'h0, c_response}, R_AFLT);
    c_address = 32'h0000_2040;
    tick();
    chk("err_above", {28'h0, c_response}, R_AFLT);
    c_address = 32'h0000_0001;
    tick();
    chk("err_prio", {28'h0, c_response}, R_MISAL);
    c_cmd = CMD_LOAD; c_address = 32'h0000_2000;
    tick();
    chk("err_cmd", {28'h0, c_response}, R_AFLT);

    // Last word in range.
    c_cmd = CMD_EXEC; c_address = 32'h0000_203C;
    tick(); c_cmd = CMD_NONE;
    chk("last_wait", {28'h0, c_response}, R_WAIT);
    tick();
    chk("last_done", {28'h0, c_response}, R_DONE);
    chk("last_data", c_load_data, 32'hCAFE_000F);
    tick();

    // Backdoor write in the last WAIT cycle is visible (write-first).
    c_cmd = CMD_EXEC; c_address = 32'h0000_2008;
    tick(); c_cmd = CMD_NONE;
    chk("wf_wait", {28'h0, c_response}, R_WAIT);
    bd_write(4'd2, 32'h1234_5678);
    chk("wf_done", {28'h0, c_response}, R_DONE);
    chk("wf_data", c_load_data, 32'h1234_5678);
    tick();

    // FLUSH_ALL: two WAIT cycles, DONE, data unchanged.
    c_cmd = CMD_FLUSH;
    tick(); c_cmd = CMD_NONE;
    chk("fl_wait0", {28'h0, c_response}, R_WAIT);
    tick();
    chk("fl_wait1", {28'h0, c_response}, R_WAIT);
    tick();
    chk("fl_done", {28'h0, c_response}, R_DONE);
    chk("fl_data", c_load_data, 32'h1234_5678);
    tick();
    chk("fl_idle", {28'h0, c_response}, R_IDLE);

    // Reset during WAIT aborts the fetch.
    c_cmd = CMD_EXEC; c_address = 32'h0000_200C;
    tick(); c_cmd = CMD_NONE;
    chk("ab_wait", {28'h0, c_response}, R_WAIT);
    rst = 1'b1;
    tick();
    chk("ab_resp", {28'h0, c_response}, R_IDLE);
    chk("ab_done", {31'h0, c_reset_done}, 32'd0);
    chk("ab_load", c_load_data, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      chk("ab_no_done", {28'h0, c_response}, R_IDLE);
      tick();
    end
    chk("ab_ready", {31'h0, c_reset_done}, 32'd1);
    chk("ab_idle", {28'h0, c_response}, R_IDLE);
    tick();
    chk("ab_idle2", {28'h0, c_response}, R_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
